// File: rtl/nibble_serial_sub_ctrl.sv
// Serial subtractor: computes a - b over WIDTH/4 cycles by reusing one 4-bit
// subtract slice, least-significant nibble first, with the borrow kept in a
// register between passes. Valid/ready handshakes on the request and result sides.
module nibble_serial_sub_ctrl #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [WIDTH-1:0] diff_o,
    output logic             borrow_o,
    output logic             ovf_o,
    output logic             zero_o,
    output logic             busy_o
);

    localparam int NIBBLES = WIDTH / 4;
    localparam int CW      = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(NIBBLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t           state_q;
    logic [CW-1:0]    cnt_q;
    logic             slice_borrow_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] diff_q;
    logic [WIDTH-1:0] diff_d;
    logic             borrow_q;
    logic             ovf_q;
    logic             zero_q;
    logic             out_valid_q;

    logic [CW+1:0]    nib_base;
    logic [3:0]       a_nib;
    logic [3:0]       b_nib;
    logic [4:0]       slice;

    // The single 4-bit slice: selects the current nibble pair and subtracts the
    // running borrow; bit 4 of the 5-bit result is the borrow out of this nibble.
    always_comb begin
        nib_base = {cnt_q, 2'b00};
        a_nib    = a_q[nib_base +: 4];
        b_nib    = b_q[nib_base +: 4];
        slice    = {1'b0, a_nib} - {1'b0, b_nib} - {4'b0000, slice_borrow_q};
        diff_d   = diff_q;
        diff_d[nib_base +: 4] = slice[3:0];
    end

    // Sequencer: accept in IDLE, one nibble per cycle in RUN, hold result in DONE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            cnt_q          <= '0;
            slice_borrow_q <= 1'b0;
            a_q            <= '0;
            b_q            <= '0;
            diff_q         <= '0;
            borrow_q       <= 1'b0;
            ovf_q          <= 1'b0;
            zero_q         <= 1'b0;
            out_valid_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid_i) begin
                        a_q            <= a_i;
                        b_q            <= b_i;
                        cnt_q          <= '0;
                        slice_borrow_q <= 1'b0;
                        state_q        <= RUN;
                    end
                end
                RUN: begin
                    diff_q         <= diff_d;
                    slice_borrow_q <= slice[4];
                    if (cnt_q == LAST) begin
                        cnt_q       <= '0;
                        borrow_q    <= slice[4];
                        ovf_q       <= (a_q[WIDTH-1] != b_q[WIDTH-1]) &&
                                       (diff_d[WIDTH-1] != a_q[WIDTH-1]);
                        zero_q      <= ~|diff_d;
                        out_valid_q <= 1'b1;
                        state_q     <= DONE;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready_i) begin
                        out_valid_q <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // Status outputs decoded from the state; ready stays low while reset is held.
    always_comb begin
        in_ready_o  = (state_q == IDLE) && rst_n;
        busy_o      = (state_q != IDLE);
        out_valid_o = out_valid_q;
        diff_o      = diff_q;
        borrow_o    = borrow_q;
        ovf_o       = ovf_q;
        zero_o      = zero_q;
    end

endmodule

// File: tb/tb_nibble_serial_sub_ctrl.sv
// Bench for nibble_serial_sub_ctrl (WIDTH=16): directed vectors with literal
// expectations plus a transaction-level model compared every cycle.
module tb_nibble_serial_sub_ctrl;

    localparam int WIDTH   = 16;
    localparam int NIBBLES = WIDTH / 4;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] diff;
    logic             borrow;
    logic             ovf;
    logic             zero;
    logic             busy;

    int vectors     = 0;
    int miscompares = 0;

    // Model state: one operation in flight, counted in edges since acceptance.
    bit               mInFlight = 1'b0;
    int               mCyc      = 0;
    int               acceptCount = 0;
    logic [WIDTH-1:0] mExpDiff  = '0;
    logic             mExpBorrow = 1'b0;
    logic             mExpOvf   = 1'b0;
    logic             mExpZero  = 1'b0;

    nibble_serial_sub_ctrl #(.WIDTH(WIDTH)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .a_i         (a),
        .b_i         (b),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .diff_o      (diff),
        .borrow_o    (borrow),
        .ovf_o       (ovf),
        .zero_o      (zero),
        .busy_o      (busy)
    );

    // Free-running 10-time-unit clock.
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference model: computes the result arithmetically on acceptance and
    // tracks only when it must appear and when it is handed off.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mInFlight = 1'b0;
            mCyc      = 0;
        end else if (!mInFlight) begin
            if (in_valid) begin
                int sd;
                sd         = int'($signed(a)) - int'($signed(b));
                mExpDiff   = a - b;
                mExpBorrow = (a < b);
                mExpOvf    = (sd > 32767) || (sd < -32768);
                mExpZero   = (a == b);
                mInFlight  = 1'b1;
                mCyc       = 0;
                acceptCount++;
            end
        end else if (mCyc == NIBBLES) begin
            if (out_ready) mInFlight = 1'b0;
        end else begin
            mCyc++;
        end
    end

    // Per-cycle comparison of the DUT against the model, away from the active edge.
    always @(negedge clk) begin
        if (rst_n) begin
            checkOutput("cyc in_ready", 32'(in_ready), 32'(!mInFlight));
            checkOutput("cyc busy", 32'(busy), 32'(mInFlight));
            checkOutput("cyc out_valid", 32'(out_valid), 32'(mInFlight && mCyc == NIBBLES));
            if (mInFlight && mCyc == NIBBLES) begin
                checkOutput("cyc diff", 32'(diff), 32'(mExpDiff));
                checkOutput("cyc borrow", 32'(borrow), 32'(mExpBorrow));
                checkOutput("cyc ovf", 32'(ovf), 32'(mExpOvf));
                checkOutput("cyc zero", 32'(zero), 32'(mExpZero));
            end
        end
    end

    task automatic waitReady(input string name);
        int guard = 0;
        while (!in_ready && guard < 50) begin
            @(posedge clk); #1;
            guard++;
        end
        checkOutput({name, " ready before request"}, 32'(in_ready), 32'd1);
    endtask

    // One full operation with literal expectations, optional back-pressure and
    // an optional second request presented while the result is stalled.
    task automatic applyStimulus(input string name, input logic [15:0] av, input logic [15:0] bv,
                                 input int stall, input bit presentNext,
                                 input logic [15:0] nA, input logic [15:0] nB,
                                 input logic [15:0] eDiff, input bit eBorrow,
                                 input bit eOvf, input bit eZero);
        int lat = 0;
        waitReady(name);
        in_valid  = 1'b1;
        a         = av;
        b         = bv;
        out_ready = (stall == 0);
        @(posedge clk); #1;
        in_valid = 1'b0;
        a        = 16'($urandom);
        b        = 16'($urandom);
        while (!out_valid && lat < 20) begin
            checkOutput({name, " in_ready low in run"}, 32'(in_ready), 32'd0);
            a = 16'($urandom);
            b = 16'($urandom);
            @(posedge clk); #1;
            lat++;
        end
        checkOutput({name, " latency"}, 32'(lat), 32'(NIBBLES));
        checkOutput({name, " diff"}, 32'(diff), 32'(eDiff));
        checkOutput({name, " borrow"}, 32'(borrow), 32'(eBorrow));
        checkOutput({name, " ovf"}, 32'(ovf), 32'(eOvf));
        checkOutput({name, " zero"}, 32'(zero), 32'(eZero));
        checkOutput({name, " busy in done"}, 32'(busy), 32'd1);
        checkOutput({name, " in_ready in done"}, 32'(in_ready), 32'd0);
        checkOutput({name, " model diff"}, 32'(mExpDiff), 32'(eDiff));
        checkOutput({name, " model borrow"}, 32'(mExpBorrow), 32'(eBorrow));
        checkOutput({name, " model ovf"}, 32'(mExpOvf), 32'(eOvf));
        for (int i = 0; i < stall; i++) begin
            if (presentNext) begin
                in_valid = 1'b1;
                a        = nA;
                b        = nB;
            end
            @(posedge clk); #1;
            checkOutput({name, " held out_valid"}, 32'(out_valid), 32'd1);
            checkOutput({name, " held diff"}, 32'(diff), 32'(eDiff));
            checkOutput({name, " held zero"}, 32'(zero), 32'(eZero));
            checkOutput({name, " held busy"}, 32'(busy), 32'd1);
            checkOutput({name, " held in_ready"}, 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        checkOutput({name, " out_valid cleared"}, 32'(out_valid), 32'd0);
        checkOutput({name, " in_ready back"}, 32'(in_ready), 32'd1);
        checkOutput({name, " busy cleared"}, 32'(busy), 32'd0);
        out_ready = 1'b0;
        if (!presentNext) in_valid = 1'b0;
    endtask

    initial begin
        int submitted;
        int seen;
        int cyc;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = '0;
        b         = '0;
        #1;
        checkOutput("reset diff", 32'(diff), 32'd0);
        checkOutput("reset out_valid", 32'(out_valid), 32'd0);
        checkOutput("reset busy", 32'(busy), 32'd0);
        checkOutput("reset borrow", 32'(borrow), 32'd0);
        #21 rst_n = 1'b1;
        #1;
        checkOutput("in_ready after reset", 32'(in_ready), 32'd1);
        @(posedge clk); #1;

        applyStimulus("basic", 16'h1234, 16'h0234, 0, 1'b0, 16'h0, 16'h0, 16'h1000, 1'b0, 1'b0, 1'b0);
        applyStimulus("underflow", 16'h0000, 16'h0001, 0, 1'b0, 16'h0, 16'h0, 16'hFFFF, 1'b1, 1'b0, 1'b0);
        applyStimulus("negovf", 16'h8000, 16'h0001, 0, 1'b0, 16'h0, 16'h0, 16'h7FFF, 1'b0, 1'b1, 1'b0);
        applyStimulus("posovf", 16'h7FFF, 16'hFFFF, 0, 1'b0, 16'h0, 16'h0, 16'h8000, 1'b1, 1'b1, 1'b0);
        applyStimulus("backpressure", 16'hABCD, 16'hABCD, 6, 1'b1, 16'h5555, 16'h1111, 16'h0000, 1'b0, 1'b0, 1'b1);
        applyStimulus("second", 16'h5555, 16'h1111, 0, 1'b0, 16'h0, 16'h0, 16'h4444, 1'b0, 1'b0, 1'b0);

        waitReady("midrun reset");
        in_valid = 1'b1;
        a        = 16'h00FF;
        b        = 16'h0100;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        checkOutput("midrun reset diff", 32'(diff), 32'd0);
        checkOutput("midrun reset out_valid", 32'(out_valid), 32'd0);
        checkOutput("midrun reset busy", 32'(busy), 32'd0);
        checkOutput("midrun reset borrow", 32'(borrow), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        applyStimulus("after reset", 16'h0005, 16'h0003, 0, 1'b0, 16'h0, 16'h0, 16'h0002, 1'b0, 1'b0, 1'b0);

        submitted = 0;
        seen      = acceptCount;
        cyc       = 0;
        in_valid  = 1'b0;
        while ((submitted < 200 || mInFlight || in_valid) && cyc < 20000) begin
            @(posedge clk); #1;
            cyc++;
            if (in_valid && acceptCount != seen) begin
                seen     = acceptCount;
                in_valid = 1'b0;
                submitted++;
            end
            if (!in_valid) begin
                a = 16'($urandom);
                b = 16'($urandom);
                if (submitted < 200 && $urandom_range(0, 2) != 0) begin
                    in_valid = 1'b1;
                    if ($urandom_range(0, 7) == 0) a = 16'h8000;
                    if ($urandom_range(0, 7) == 0) b = a;
                end
            end
            out_ready = 1'($urandom_range(0, 1));
        end
        checkOutput("random run completed", 32'(cyc < 20000), 32'd1);
        checkOutput("random ops accepted", 32'(submitted), 32'd200);
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
